// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: holds all domain resets, then releases them in index order, each gated by its ack plus a gap.
// Optional ack timeout with sticky TIMEOUT_ERR and ERR state: define RST_SEQ_TIMEOUT_EN.
module rst_seq_ctrl #(
    parameter int unsigned NUM_DOMAINS    = 3,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned GAP_CYCLES     = 8,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SW_RST_REQ,
    input  logic [NUM_DOMAINS-1:0] DOMAIN_ACK,
    output logic [NUM_DOMAINS-1:0] DOMAIN_RST_N,
    output logic [IDX_W-1:0]       ACTIVE_IDX,
    output logic                   BUSY,
    output logic                   SEQ_DONE,
    output logic                   TIMEOUT_ERR
);

    if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8 || HOLD_CYCLES < 1 || GAP_CYCLES < 1 ||
        TIMEOUT_CYCLES < 1 || HOLD_CYCLES >= (1 << CNT_W) || GAP_CYCLES >= (1 << CNT_W) ||
        TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_param_check
        $error("rst_seq_ctrl: parameter out of range");
    end

`ifdef RST_SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {S_HOLD, S_WAIT_ACK, S_GAP, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_HOLD, S_WAIT_ACK, S_GAP, S_DONE} state_t;
`endif

    state_t                 r_state, w_state;
    logic [CNT_W-1:0]       r_cnt, w_cnt;
    logic [IDX_W-1:0]       r_idx, w_idx;
    logic [NUM_DOMAINS-1:0] r_rst_n, w_rst_n;
    logic                   r_busy, w_busy;
    logic                   r_done, w_done;
`ifdef RST_SEQ_TIMEOUT_EN
    logic [CNT_W-1:0]       r_tcnt, w_tcnt;
    logic                   r_terr, w_terr;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst_n <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
            r_tcnt  <= '0;
            r_terr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_rst_n <= w_rst_n;
            r_busy  <= w_busy;
            r_done  <= w_done;
`ifdef RST_SEQ_TIMEOUT_EN
            r_tcnt  <= w_tcnt;
            r_terr  <= w_terr;
`endif
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_rst_n = r_rst_n;
        w_busy  = r_busy;
        w_done  = r_done;
`ifdef RST_SEQ_TIMEOUT_EN
        w_tcnt  = r_tcnt;
        w_terr  = r_terr;
`endif
        if (SW_RST_REQ) begin
            w_state = S_HOLD;
            w_cnt   = '0;
            w_idx   = '0;
            w_rst_n = '0;
            w_busy  = 1'b1;
            w_done  = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
            w_tcnt  = '0;
            w_terr  = 1'b0;
`endif
        end else begin
            unique case (r_state)
                // Hold compares against HOLD_CYCLES so bit 0 rises on the HOLD_CYCLES-th edge counted from 0.
                S_HOLD: begin
                    if (r_cnt == CNT_W'(HOLD_CYCLES)) begin
                        w_rst_n[0] = 1'b1;
                        w_cnt      = '0;
                        w_state    = S_WAIT_ACK;
`ifdef RST_SEQ_TIMEOUT_EN
                        w_tcnt     = '0;
`endif
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    if (DOMAIN_ACK[r_idx]) begin
                        if (r_idx == IDX_W'(NUM_DOMAINS - 1)) begin
                            w_state = S_DONE;
                            w_busy  = 1'b0;
                            w_done  = 1'b1;
                        end else begin
                            w_cnt   = '0;
                            w_state = S_GAP;
                        end
                    end
`ifdef RST_SEQ_TIMEOUT_EN
                    else if (r_tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        w_state = S_ERR;
                        w_terr  = 1'b1;
                        w_busy  = 1'b0;
                    end else begin
                        w_tcnt = r_tcnt + 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        w_idx   = r_idx + 1'b1;
                        w_cnt   = '0;
                        w_state = S_WAIT_ACK;
`ifdef RST_SEQ_TIMEOUT_EN
                        w_tcnt  = '0;
`endif
                        for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
                            if (IDX_W'(i) == w_idx) w_rst_n[i] = 1'b1;
                        end
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign DOMAIN_RST_N = r_rst_n;
    assign ACTIVE_IDX   = r_idx;
    assign BUSY         = r_busy;
    assign SEQ_DONE     = r_done;
`ifdef RST_SEQ_TIMEOUT_EN
    assign TIMEOUT_ERR  = r_terr;
`else
    assign TIMEOUT_ERR  = 1'b0;
`endif

endmodule
